// File: rtl/tag_ram_ctrl_if.sv
// Cache-pipeline-side interface of the tag RAM controller: lookup,
// refill, single-line invalidate and flush.
// The pipeline uses the master modport and the controller uses the slave modport.
interface tag_ram_ctrl_if #(
    parameter int IDX_W = 7,
    parameter int TAG_W = 22
);
    logic             lk_valid;
    logic             lk_ready;
    logic [IDX_W-1:0] lk_index;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_resp_valid;
    logic             lk_hit;
    logic             fill_valid;
    logic             fill_ready;
    logic [IDX_W-1:0] fill_index;
    logic [TAG_W-1:0] fill_tag;
    logic             inv_valid;
    logic             inv_ready;
    logic [IDX_W-1:0] inv_index;
    logic             flush_req;
    logic             busy;

    modport master (
        output lk_valid, lk_index, lk_tag,
        output fill_valid, fill_index, fill_tag,
        output inv_valid, inv_index, flush_req,
        input  lk_ready, lk_resp_valid, lk_hit,
        input  fill_ready, inv_ready, busy
    );

    modport slave (
        input  lk_valid, lk_index, lk_tag,
        input  fill_valid, fill_index, fill_tag,
        input  inv_valid, inv_index, flush_req,
        output lk_ready, lk_resp_valid, lk_hit,
        output fill_ready, inv_ready, busy
    );
endinterface

// File: rtl/tag_ram_ctrl.sv
// Sequencer/arbiter for a 1R1W cache tag array (entry = {valid, tag}).
// The controller clears the whole array after reset and on a flush request.
// It arbitrates refill writes over invalidate writes.
// Lookups are served with a hit/miss result one cycle after acceptance.
// Optional build macro TAG_BYPASS_EN: when it is defined, a lookup and a write
// to the same index in the same cycle are both accepted, and the written data
// is forwarded into the response. When it is not defined, such a lookup
// stalls for one cycle.
module tag_ram_ctrl #(
    parameter int IDX_W = 7,
    parameter int TAG_W = 22
) (
    input  logic             clk,
    input  logic             rst,
    tag_ram_ctrl_if.slave    bus,
    output logic             ram_re,
    output logic [IDX_W-1:0] ram_raddr,
    input  logic [TAG_W:0]   ram_rd,
    output logic             ram_we,
    output logic [IDX_W-1:0] ram_waddr,
    output logic [TAG_W:0]   ram_wr
);

    typedef enum logic [1:0] {INIT, RUN, FLUSH} state_t;

    state_t           state, next_state;
    logic [IDX_W-1:0] cnt, next_cnt;
    logic             pend;
    logic [TAG_W-1:0] tag_q;
    logic             wr_acc;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W:0]   wr_data;
    logic             lk_acc;
    logic [TAG_W:0]   rd_data;

    // State register and clear-walk counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next state, write-port arbitration and handshake outputs.
    // Everything is forced idle while reset is held.
    always_comb begin
        next_state     = state;
        next_cnt       = cnt;
        bus.busy       = 1'b1;
        bus.lk_ready   = 1'b0;
        bus.fill_ready = 1'b0;
        bus.inv_ready  = 1'b0;
        wr_acc         = 1'b0;
        wr_idx         = bus.fill_index;
        wr_data        = {1'b1, bus.fill_tag};
        lk_acc         = 1'b0;
        ram_we         = 1'b0;
        ram_waddr      = cnt;
        ram_wr         = '0;
        ram_re         = 1'b0;
        ram_raddr      = bus.lk_index;
        case (state)
            INIT, FLUSH: begin
                ram_we   = 1'b1;
                next_cnt = cnt + 1'b1;
                if (cnt == {IDX_W{1'b1}}) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b0;
                if (bus.flush_req) begin
                    next_state = FLUSH;
                    next_cnt   = '0;
                end else begin
                    bus.fill_ready = 1'b1;
                    bus.inv_ready  = !bus.fill_valid;
                    if (bus.fill_valid) begin
                        wr_acc = 1'b1;
                    end else if (bus.inv_valid) begin
                        wr_acc  = 1'b1;
                        wr_idx  = bus.inv_index;
                        wr_data = '0;
                    end
`ifdef TAG_BYPASS_EN
                    bus.lk_ready = 1'b1;
`else
                    bus.lk_ready = !(wr_acc && (wr_idx == bus.lk_index));
`endif
                    lk_acc    = bus.lk_valid && bus.lk_ready;
                    ram_re    = lk_acc;
                    ram_we    = wr_acc;
                    ram_waddr = wr_idx;
                    ram_wr    = wr_data;
                end
            end
            default: begin
                next_state = INIT;
                next_cnt   = '0;
            end
        endcase
        if (!rst) begin
            bus.busy       = 1'b1;
            bus.lk_ready   = 1'b0;
            bus.fill_ready = 1'b0;
            bus.inv_ready  = 1'b0;
            wr_acc         = 1'b0;
            lk_acc         = 1'b0;
            ram_we         = 1'b0;
            ram_re         = 1'b0;
        end
    end

`ifdef TAG_BYPASS_EN
    logic           fwd_q;
    logic [TAG_W:0] fwd_data_q;

    // Capture the write that collides with an accepted lookup so the response sees the new entry
    always_ff @(posedge clk) begin
        if (!rst) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_q      <= lk_acc && wr_acc && (wr_idx == bus.lk_index);
            fwd_data_q <= wr_data;
        end
    end

    assign rd_data = fwd_q ? fwd_data_q : ram_rd;
`else
    assign rd_data = ram_rd;
`endif

    // Lookup pipeline: remember the tag under comparison and that a response is due
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend  <= 1'b0;
            tag_q <= '0;
        end else begin
            pend <= lk_acc;
            if (lk_acc) begin
                tag_q <= bus.lk_tag;
            end
        end
    end

    assign bus.lk_resp_valid = pend && rst;
    assign bus.lk_hit        = bus.lk_resp_valid && rd_data[TAG_W] &&
                               (rd_data[TAG_W-1:0] == tag_q);

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// Self-checking bench for tag_ram_ctrl: directed scenarios plus random traffic
// compared against an array-level model of the tag contents.
// TAG_BYPASS_EN selects the same-index lookup/write acceptance rule.
module tb_tag_ram_ctrl;

    logic        clk;
    logic        rst;
    logic        ram_re;
    logic [6:0]  ram_raddr;
    logic [22:0] ram_rd;
    logic        ram_we;
    logic [6:0]  ram_waddr;
    logic [22:0] ram_wr;
    logic [22:0] ram_mem [128];

    int assert_count = 0;
    int fail_count   = 0;

    logic [22:0] ref_mem [128];
    int          walk_left;
    int          walk_addr;
    bit          exp_pend;
    bit          exp_hit;

    tag_ram_ctrl_if #(.IDX_W(7), .TAG_W(22)) bus ();

    tag_ram_ctrl #(.IDX_W(7), .TAG_W(22)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ram_re    (ram_re),
        .ram_raddr (ram_raddr),
        .ram_rd    (ram_rd),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wr    (ram_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tag RAM macro: registered read that returns the old data on a read-during-write
    always @(posedge clk) begin
        if (ram_re) ram_rd <= ram_mem[ram_raddr];
        if (ram_we) ram_mem[ram_waddr] <= ram_wr;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 128; i++) ref_mem[i] = '0;
        walk_left = 128;
        walk_addr = 0;
        exp_pend  = 1'b0;
    endtask

    // Compare this cycle's outputs against the model, then advance the model past the coming edge
    task automatic evalCycle(input bit in_rst);
        bit          f_acc, i_acc, w_acc, l_acc, exp_lk_ready;
        logic [6:0]  w_idx;
        logic [22:0] w_data;
        logic [22:0] entry;
        if (in_rst) begin
            checkOutput("rst_busy", bus.busy, 1);
            checkOutput("rst_lk_ready", bus.lk_ready, 0);
            checkOutput("rst_fill_ready", bus.fill_ready, 0);
            checkOutput("rst_inv_ready", bus.inv_ready, 0);
            checkOutput("rst_resp_valid", bus.lk_resp_valid, 0);
            checkOutput("rst_hit", bus.lk_hit, 0);
            checkOutput("rst_ram_we", ram_we, 0);
            checkOutput("rst_ram_re", ram_re, 0);
            clearModel();
        end else begin
            checkOutput("resp_valid", bus.lk_resp_valid, exp_pend);
            checkOutput("hit", bus.lk_hit, exp_pend ? exp_hit : 1'b0);
            if (walk_left > 0) begin
                checkOutput("walk_busy", bus.busy, 1);
                checkOutput("walk_lk_ready", bus.lk_ready, 0);
                checkOutput("walk_fill_ready", bus.fill_ready, 0);
                checkOutput("walk_inv_ready", bus.inv_ready, 0);
                checkOutput("walk_ram_re", ram_re, 0);
                checkOutput("walk_ram_we", ram_we, 1);
                checkOutput("walk_waddr", ram_waddr, walk_addr);
                checkOutput("walk_wdata", ram_wr, 0);
                walk_addr++;
                walk_left--;
                exp_pend = 1'b0;
            end else if (bus.flush_req) begin
                checkOutput("flush_busy", bus.busy, 0);
                checkOutput("flush_lk_ready", bus.lk_ready, 0);
                checkOutput("flush_fill_ready", bus.fill_ready, 0);
                checkOutput("flush_inv_ready", bus.inv_ready, 0);
                checkOutput("flush_ram_we", ram_we, 0);
                checkOutput("flush_ram_re", ram_re, 0);
                clearModel();
            end else begin
                f_acc  = bus.fill_valid;
                i_acc  = bus.inv_valid && !bus.fill_valid;
                w_acc  = f_acc || i_acc;
                w_idx  = f_acc ? bus.fill_index : bus.inv_index;
                w_data = f_acc ? {1'b1, bus.fill_tag} : 23'd0;
`ifdef TAG_BYPASS_EN
                exp_lk_ready = 1'b1;
`else
                exp_lk_ready = !(w_acc && (w_idx == bus.lk_index));
`endif
                l_acc = bus.lk_valid && exp_lk_ready;
                checkOutput("run_busy", bus.busy, 0);
                checkOutput("fill_ready", bus.fill_ready, 1);
                checkOutput("inv_ready", bus.inv_ready, !bus.fill_valid);
                checkOutput("lk_ready", bus.lk_ready, exp_lk_ready);
                checkOutput("ram_we", ram_we, w_acc);
                if (w_acc) begin
                    checkOutput("ram_waddr", ram_waddr, w_idx);
                    checkOutput("ram_wr", ram_wr, w_data);
                    ref_mem[w_idx] = w_data;
                end
                checkOutput("ram_re", ram_re, l_acc);
                if (l_acc) begin
                    checkOutput("ram_raddr", ram_raddr, bus.lk_index);
                    entry   = ref_mem[bus.lk_index];
                    exp_hit = entry[22] && (entry[21:0] == bus.lk_tag);
                end
                exp_pend = l_acc;
            end
        end
    endtask

    task automatic applyStimulus(input bit rs, input bit lv, input logic [6:0] li, input logic [21:0] lt,
                                 input bit fv, input logic [6:0] fi, input logic [21:0] ft,
                                 input bit iv, input logic [6:0] ii, input bit fl);
        @(negedge clk);
        rst            = !rs;
        bus.lk_valid   = lv;
        bus.lk_index   = li;
        bus.lk_tag     = lt;
        bus.fill_valid = fv;
        bus.fill_index = fi;
        bus.fill_tag   = ft;
        bus.inv_valid  = iv;
        bus.inv_index  = ii;
        bus.flush_req  = fl;
        #1;
        evalCycle(rs);
    endtask

    task automatic idleCycles(input int n, input bit rs);
        for (int i = 0; i < n; i++) applyStimulus(rs, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [21:0] pickTag();
        case ($urandom_range(0, 3))
            0: pickTag = 22'h55;
            1: pickTag = 22'h12345;
            2: pickTag = 22'h56;
            default: pickTag = 22'($urandom);
        endcase
    endfunction

    function automatic logic [6:0] pickIdx();
        pickIdx = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7));
    endfunction

    initial begin
        for (int i = 0; i < 128; i++) ram_mem[i] = 23'($urandom);
        rst            = 1'b0;
        bus.lk_valid   = 1'b0;
        bus.lk_index   = '0;
        bus.lk_tag     = '0;
        bus.fill_valid = 1'b0;
        bus.fill_index = '0;
        bus.fill_tag   = '0;
        bus.inv_valid  = 1'b0;
        bus.inv_index  = '0;
        bus.flush_req  = 1'b0;
        clearModel();

        idleCycles(2, 1);
        idleCycles(129, 0);

        applyStimulus(0, 0, 0, 0, 1, 5, 22'h12345, 0, 0, 0);
        applyStimulus(0, 1, 5, 22'h12345, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 5, 22'h12346, 0, 0, 0, 0, 0, 0);
        idleCycles(1, 0);

        applyStimulus(0, 0, 0, 0, 1, 3, 22'h333, 1, 9, 0);
        applyStimulus(0, 1, 3, 22'h333, 0, 0, 0, 1, 9, 0);
        applyStimulus(0, 1, 9, 22'h0, 0, 0, 0, 0, 0, 0);
        idleCycles(1, 0);

        applyStimulus(0, 0, 0, 0, 1, 7, 22'hABC, 0, 0, 0);
        applyStimulus(0, 1, 7, 22'hABC, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 7, 22'hABC, 0, 0, 0, 0, 0, 1);
        idleCycles(127, 0);
        applyStimulus(0, 1, 7, 22'hABC, 0, 0, 0, 0, 0, 0);
        idleCycles(1, 0);

        applyStimulus(0, 1, 20, 22'h55, 1, 20, 22'h55, 0, 0, 0);
        applyStimulus(0, 1, 20, 22'h55, 0, 0, 0, 0, 0, 0);
        idleCycles(1, 0);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idleCycles(60, 0);
        idleCycles(2, 1);
        idleCycles(129, 0);

        applyStimulus(0, 1, 20, 22'h55, 0, 0, 0, 0, 0, 0);
        idleCycles(1, 1);
        idleCycles(130, 0);

        for (int i = 0; i < 2000; i++) begin
            applyStimulus(0,
                          $urandom_range(0, 99) < 60, pickIdx(), pickTag(),
                          $urandom_range(0, 99) < 30, pickIdx(), pickTag(),
                          $urandom_range(0, 99) < 25, pickIdx(),
                          $urandom_range(0, 199) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
